// File: rtl/ep_arb.sv
// TRN-tx arbiter between the rx engine (A) and tx engine (B): round-robin grant with one
// dead cycle between owners, plus the shared 5-bit tag counter. Optional watchdog: EP_ARB_WATCHDOG_EN.
module ep_arb #(
  parameter int TMO = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_ep_a,
  input  logic       drv_ep_a,
  input  logic       tag_inc_a,
  output logic       my_trn_a,
  input  logic       req_ep_b,
  input  logic       drv_ep_b,
  input  logic       tag_inc_b,
  output logic       my_trn_b,
  output logic [4:0] tag_trn,
  output logic       tag_err,
  output logic       wdog_expired
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;
  localparam logic [1:0] TURN  = 2'd3;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  localparam logic [15:0] TMO_W = 16'(TMO);

  logic [1:0] state, state_nx;
  logic       last, last_nx;
  logic       wdog_hit;
  logic       own_inc, bad_inc;

  // IDLE and TURN share this: a lone request wins, a tie goes to whoever was not served last.
  function automatic logic [1:0] arbitrate(input logic ra, input logic rb, input logic lst);
    logic [1:0] nx;
    nx = IDLE;
    if (ra && rb)  nx = (lst == LAST_B) ? GNT_A : GNT_B;
    else if (ra)   nx = GNT_A;
    else if (rb)   nx = GNT_B;
    return nx;
  endfunction

  function automatic logic [4:0] tag_next(input logic [4:0] t);
    return t + 5'd1;
  endfunction

  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      GNT_A: if (!(req_ep_a || drv_ep_a) || wdog_hit) state_nx = TURN;
      GNT_B: if (!(req_ep_b || drv_ep_b) || wdog_hit) state_nx = TURN;
      default: begin
        state_nx = arbitrate(req_ep_a, req_ep_b, last);
        if (state_nx == GNT_A)      last_nx = LAST_A;
        else if (state_nx == GNT_B) last_nx = LAST_B;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= LAST_B;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  assign my_trn_a = (state == GNT_A);
  assign my_trn_b = (state == GNT_B);

  // Only the current owner may advance the tag; any other pulse is a protocol error.
  assign own_inc = ((state == GNT_A) && tag_inc_a) || ((state == GNT_B) && tag_inc_b);
  assign bad_inc = (tag_inc_a && (state != GNT_A)) || (tag_inc_b && (state != GNT_B));

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_trn <= 5'd0;
      tag_err <= 1'b0;
    end else begin
      if (own_inc) tag_trn <= tag_next(tag_trn);
      if (bad_inc) tag_err <= 1'b1;
    end
  end

`ifdef EP_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt;
  logic        drv_seen;
  logic        in_gnt, own_req, own_drv;

  assign in_gnt  = (state == GNT_A) || (state == GNT_B);
  assign own_req = (state == GNT_A) ? req_ep_a : req_ep_b;
  assign own_drv = (state == GNT_A) ? drv_ep_a : drv_ep_b;

  // Fires on the TMO-th grant cycle in which the owner still has not started driving.
  assign wdog_hit = in_gnt && !drv_seen && !own_drv && own_req && (wd_cnt == TMO_W - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt       <= 16'd0;
      drv_seen     <= 1'b0;
      wdog_expired <= 1'b0;
    end else begin
      wdog_expired <= wdog_hit;
      if (!in_gnt) begin
        wd_cnt   <= 16'd0;
        drv_seen <= 1'b0;
      end else if (!drv_seen) begin
        if (own_drv) drv_seen <= 1'b1;
        else         wd_cnt   <= wd_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo   = ^TMO_W;
  assign wdog_hit     = 1'b0;
  assign wdog_expired = 1'b0;
`endif

endmodule

// File: tb/tb_ep_arb.sv
// Self-checking bench for ep_arb: directed scenarios plus randomized traffic against an
// owner/last-served reference model. Watchdog expectations follow EP_ARB_WATCHDOG_EN.
module tb_ep_arb;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, drv_a, inc_a, my_a;
  logic       req_b, drv_b, inc_b, my_b;
  logic [4:0] tag;
  logic       err, wexp;
  logic [8:0] obs;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the bus (0 none, 1 A, 2 B) and who was served last.
  int m_owner, m_last, m_tag, m_age;
  bit m_err, m_seen, m_wexp;

  ep_arb #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_ep_a(req_a), .drv_ep_a(drv_a), .tag_inc_a(inc_a), .my_trn_a(my_a),
    .req_ep_b(req_b), .drv_ep_b(drv_b), .tag_inc_b(inc_b), .my_trn_b(my_b),
    .tag_trn(tag), .tag_err(err), .wdog_expired(wexp)
  );

  always #5 clk = ~clk;

  assign obs = {my_a, my_b, tag, err, wexp};

  function automatic logic [8:0] exp_vec();
    return {m_owner == 1, m_owner == 2, 5'(m_tag), m_err, m_wexp};
  endfunction

  task automatic model_step();
    int o;
    bit req, drv;
    if (rst) begin
      m_owner = 0; m_last = 2; m_tag = 0; m_err = 0; m_wexp = 0; m_age = 0; m_seen = 0;
      return;
    end
    o = m_owner;
    m_wexp = 0;
    if ((inc_a && o != 1) || (inc_b && o != 2)) m_err = 1;
    if ((inc_a && o == 1) || (inc_b && o == 2)) m_tag = (m_tag + 1) % 32;
    if (o != 0) begin
      req = (o == 1) ? req_a : req_b;
      drv = (o == 1) ? drv_a : drv_b;
      if (!req && !drv) m_owner = 0;
`ifdef EP_ARB_WATCHDOG_EN
      else if (drv) m_seen = 1;
      else if (!m_seen) begin
        m_age++;
        if (m_age >= TMO) begin
          m_owner = 0;
          m_wexp  = 1;
        end
      end
`endif
    end else begin
      if (req_a && req_b) m_owner = (m_last == 2) ? 1 : 2;
      else if (req_a)     m_owner = 1;
      else if (req_b)     m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner;
        m_age  = 0;
        m_seen = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    req_a = 0; drv_a = 0; inc_a = 0;
    req_b = 0; drv_b = 0; inc_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_a = 1; req_b = 1;
    tick();
    checks++;
    if (obs !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want %h", obs, 9'd0);
    end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_single_grant();
    do_reset();
    req_a = 1;
    tick();
    req_a = 0;
    checks++;
    if (my_a !== 1'b1 || my_b !== 1'b0 || tag !== 5'd0) begin
      failures++;
      $display("FAIL single_grant: got a=%b b=%b tag=%0d want a=1 b=0 tag=0", my_a, my_b, tag);
    end
    tick();
    checks++;
    if (my_a !== 1'b0 || my_b !== 1'b0) begin
      failures++;
      $display("FAIL single_release: got a=%b b=%b want a=0 b=0", my_a, my_b);
    end
    tick();
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL single_idle: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int gaps[$];
    int gap, cnt_a, cnt_b;
    bit prev_any;
    int want[4];
    want = '{1, 2, 1, 2};
    do_reset();
    gap = 0; cnt_a = 0; cnt_b = 0; prev_any = 0;
    req_a = 1; req_b = 1;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL rr_model cyc=%0d: got %h want %h", c, obs, exp_vec());
      end
      checks++;
      if (my_a && my_b) begin
        failures++;
        $display("FAIL rr_exclusive cyc=%0d: got a=1 b=1 want at most one", c);
      end
      if (my_a || my_b) begin
        if (!prev_any) begin
          order.push_back(my_a ? 1 : 2);
          gaps.push_back(gap);
        end
        gap = 0;
      end else gap++;
      prev_any = my_a || my_b;
      if (my_a) begin cnt_a++; req_a = (cnt_a <= 4); drv_a = (cnt_a <= 4); end
      else begin cnt_a = 0; req_a = 1; drv_a = 0; end
      if (my_b) begin cnt_b++; req_b = (cnt_b <= 4); drv_b = (cnt_b <= 4); end
      else begin cnt_b = 0; req_b = 1; drv_b = 0; end
    end
    checks++;
    if (order.size() != 4) begin
      failures++;
      $display("FAIL rr_timeout: got %0d grants want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != want[i]) begin
          failures++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], want[i]);
        end
        if (i > 0) begin
          checks++;
          if (gaps[i] != 1) begin
            failures++;
            $display("FAIL rr_dead_cycle[%0d]: got %0d want 1", i, gaps[i]);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_tag_wrap();
    int exp_tag;
    do_reset();
    req_a = 1; drv_a = 1;
    tick();
    exp_tag = 0;
    for (int i = 0; i < 33; i++) begin
      if (i == 10) begin
        inc_a = 0; inc_b = 1;
        tick();
        inc_b = 0;
        checks++;
        if (tag !== 5'(exp_tag) || err !== 1'b1) begin
          failures++;
          $display("FAIL tag_nonowner: got tag=%0d err=%b want tag=%0d err=1", tag, err, exp_tag);
        end
      end
      inc_a = 1;
      tick();
      exp_tag = (exp_tag + 1) % 32;
      checks++;
      if (tag !== 5'(exp_tag) || err !== (i >= 10)) begin
        failures++;
        $display("FAIL tag_seq[%0d]: got tag=%0d err=%b want tag=%0d err=%b", i, tag, err, exp_tag, i >= 10);
      end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (err !== 1'b1 || tag !== 5'd1) begin
      failures++;
      $display("FAIL tag_err_sticky: got err=%b tag=%0d want err=1 tag=1", err, tag);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (err !== 1'b0 || tag !== 5'd0) begin
      failures++;
      $display("FAIL tag_err_clear: got err=%b tag=%0d want err=0 tag=0", err, tag);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req_b = 1; drv_b = 1;
    tick();
    for (int i = 0; i < 7; i++) begin
      inc_b = 1;
      tick();
    end
    inc_b = 0;
    checks++;
    if (tag !== 5'd7 || my_b !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: got tag=%0d b=%b want tag=7 b=1", tag, my_b);
    end
    rst = 1; req_a = 1;
    tick();
    checks++;
    if (obs !== 9'd0) begin
      failures++;
      $display("FAIL mid_reset: got %h want %h", obs, 9'd0);
    end
    rst = 0;
    tick();
    checks++;
    if (my_a !== 1'b1 || my_b !== 1'b0) begin
      failures++;
      $display("FAIL mid_first_a: got a=%b b=%b want a=1 b=0", my_a, my_b);
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    int b_low, w_first, w_cnt, a_first;
    b_low = -1; w_first = -1; w_cnt = 0; a_first = -1;
    do_reset();
    req_b = 1;
    for (int idx = 0; idx < 100; idx++) begin
      tick();
      if (idx == 0) req_a = 1;
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL wd_model idx=%0d: got %h want %h", idx, obs, exp_vec());
      end
      if (!my_b && b_low < 0) b_low = idx;
      if (wexp && w_first < 0) w_first = idx;
      if (wexp && idx < 16) w_cnt++;
      if (my_a && a_first < 0) a_first = idx;
    end
`ifdef EP_ARB_WATCHDOG_EN
    checks++;
    if (b_low != TMO || w_first != TMO || w_cnt != 1 || a_first != TMO + 1) begin
      failures++;
      $display("FAIL wd_revoke: got b_low=%0d w_first=%0d w_cnt=%0d a_first=%0d want %0d %0d 1 %0d",
               b_low, w_first, w_cnt, a_first, TMO, TMO, TMO + 1);
    end
`else
    checks++;
    if (b_low != -1 || w_first != -1 || a_first != -1) begin
      failures++;
      $display("FAIL wd_hold: got b_low=%0d w_first=%0d a_first=%0d want -1 -1 -1",
               b_low, w_first, a_first);
    end
`endif
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      req_a = ($urandom_range(0, 1) == 1);
      req_b = ($urandom_range(0, 1) == 1);
      drv_a = ($urandom_range(0, 3) == 0);
      drv_b = ($urandom_range(0, 3) == 0);
      inc_a = ($urandom_range(0, 5) == 0);
      inc_b = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    tick();
    tick();
    test_reset();
    test_single_grant();
    test_round_robin();
    test_tag_wrap();
    test_reset_mid_grant();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
